// File: rtl/btd_pkg.sv
// Shared types and width helpers for the truncated divider and its rounding front end.
package btd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } btd_state_e;

    // Width of an operand after DAC LSBs have been rounded away.
    function automatic int rc_width(input int w, input int dac);
        return w - dac;
    endfunction

    // Iteration counter width; must hold n-1.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btd_if.sv
// Operand/result handshake bundle for the truncated divider.
interface btd_if #(
    parameter int DA = 10,
    parameter int DB = 10
);
    logic          i_valid;
    logic          o_ready;
    logic [DA-1:0] i_a;
    logic [DB-1:0] i_b;
    logic          o_valid;
    logic          i_ready;
    logic [DA-1:0] o_q;
    logic [DB-1:0] o_r;
    logic          o_dz;

    modport master (
        output i_valid, i_a, i_b, i_ready,
        input  o_ready, o_valid, o_q, o_r, o_dz
    );

    modport slave (
        input  i_valid, i_a, i_b, i_ready,
        output o_ready, o_valid, o_q, o_r, o_dz
    );
endinterface

// File: rtl/rnd_sat.sv
// Round-half-up of the DAC LSBs with saturation to the reduced width.
module rnd_sat
    import btd_pkg::*;
#(
    parameter int W   = 10,
    parameter int DAC = 1
) (
    input  logic [W-1:0]                  x,
    output logic [rc_width(W, DAC)-1:0]   x_rc
);

    generate
        if (DAC == 0) begin : g_pass
            assign x_rc = x;
        end else begin : g_round
            logic [W-DAC:0] sum;
            logic           unused_lsbs;

            // Adding half an LSB then shifting reduces to adding the top dropped bit.
            assign sum         = {1'b0, x[W-1:DAC]} + {{(W-DAC){1'b0}}, x[DAC-1]};
            assign x_rc        = sum[W-DAC] ? '1 : sum[W-DAC-1:0];
            assign unused_lsbs = ^x[DAC-1:0];
        end
    endgenerate

endmodule

// File: rtl/btd_seq.sv
// Sequential truncated divider: rounds both operands, then restoring division one bit per cycle.
//   state | meaning
//   IDLE  | ready for operands
//   CALC  | restoring iterations, one quotient bit per cycle
//   DONE  | result held until downstream accepts
module btd_seq
    import btd_pkg::*;
#(
    parameter int DA  = 10,
    parameter int DB  = 10,
    parameter int DAC = 1
) (
    input logic  i_clk,
    input logic  i_rst,
    btd_if.slave bus
);

    localparam int N  = rc_width(DA, DAC);
    localparam int NB = rc_width(DB, DAC);
    localparam int CW = cnt_width(N);

    btd_state_e      state_q, state_d;
    logic            accept;
    logic [N-1:0]    a_rc, a_sh_q;
    logic [NB-1:0]   b_rc, b_q;
    logic [NB:0]     rem_q, rem_sh, rem_sub;
    logic            ge;
    logic [DA-1:0]   q_q;
    logic            dz_q;
    logic [CW-1:0]   cnt_q;

    rnd_sat #(.W(DA), .DAC(DAC)) u_rnd_a (.x(bus.i_a), .x_rc(a_rc));
    rnd_sat #(.W(DB), .DAC(DAC)) u_rnd_b (.x(bus.i_b), .x_rc(b_rc));

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        bus.o_ready = 1'b0;
        bus.o_valid = 1'b0;
        case (state_q)
            IDLE: begin
                bus.o_ready = 1'b1;
                if (bus.i_valid) begin
                    accept  = 1'b1;
                    state_d = (b_rc == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt_q == '0) state_d = DONE;
            end
            DONE: begin
                bus.o_valid = 1'b1;
                if (bus.i_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The remainder's MSB always shifts out because the stored remainder is < b_q.
    assign rem_sh  = (rem_q << 1) | (NB + 1)'(a_sh_q[N-1]);
    assign ge      = (rem_sh >= {1'b0, b_q});
    assign rem_sub = rem_sh - {1'b0, b_q};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            a_sh_q <= '0;
            b_q    <= '0;
            rem_q  <= '0;
            q_q    <= '0;
            dz_q   <= 1'b0;
            cnt_q  <= '0;
        end else if (accept) begin
            a_sh_q <= a_rc;
            b_q    <= b_rc;
            rem_q  <= '0;
            cnt_q  <= CW'(N - 1);
            if (b_rc == '0) begin
                q_q  <= '1;
                dz_q <= 1'b1;
            end else begin
                q_q  <= '0;
                dz_q <= 1'b0;
            end
        end else if (state_q == CALC) begin
            a_sh_q <= a_sh_q << 1;
            rem_q  <= ge ? rem_sub : rem_sh;
            q_q    <= {q_q[DA-2:0], ge};
            if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        end
    end

    assign bus.o_q  = q_q;
    assign bus.o_r  = DB'(rem_q) << DAC;
    assign bus.o_dz = dz_q;

endmodule

// File: tb/tb_btd_seq.sv
// Self-checking bench for btd_seq: directed plan vectors, random ops, backpressure and mid-op reset.
module tb_btd_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    btd_if #(.DA(10), .DB(10)) bus1 ();
    btd_if #(.DA(10), .DB(10)) bus2 ();

    btd_seq #(.DA(10), .DB(10), .DAC(1)) u_dut1 (.i_clk(clk), .i_rst(rst), .bus(bus1));
    btd_seq #(.DA(10), .DB(10), .DAC(2)) u_dut2 (.i_clk(clk), .i_rst(rst), .bus(bus2));

    int         cur = 0;
    logic       drv_valid = 1'b0;
    logic       drv_ready = 1'b0;
    logic [9:0] drv_a = '0;
    logic [9:0] drv_b = '0;

    assign bus1.i_valid = drv_valid & (cur == 0);
    assign bus2.i_valid = drv_valid & (cur == 1);
    assign bus1.i_a     = drv_a;
    assign bus2.i_a     = drv_a;
    assign bus1.i_b     = drv_b;
    assign bus2.i_b     = drv_b;
    assign bus1.i_ready = drv_ready & (cur == 0);
    assign bus2.i_ready = drv_ready & (cur == 1);

    logic       mon_ready, mon_valid, mon_dz;
    logic [9:0] mon_q, mon_r;
    assign mon_ready = (cur == 1) ? bus2.o_ready : bus1.o_ready;
    assign mon_valid = (cur == 1) ? bus2.o_valid : bus1.o_valid;
    assign mon_dz    = (cur == 1) ? bus2.o_dz    : bus1.o_dz;
    assign mon_q     = (cur == 1) ? bus2.o_q     : bus1.o_q;
    assign mon_r     = (cur == 1) ? bus2.o_r     : bus1.o_r;

    int tests = 0;
    int fails = 0;

    // Reference: quotient of the rounded operands, computed directly with integer arithmetic.
    function automatic void model(input int a, input int b, input int dac,
                                  output int q, output int r, output bit dz, output int lat);
        int half, lim, arc, brc;
        half = (dac > 0) ? (1 << (dac - 1)) : 0;
        lim  = (1 << (10 - dac)) - 1;
        arc  = (a + half) >> dac;
        brc  = (b + half) >> dac;
        if (arc > lim) arc = lim;
        if (brc > lim) brc = lim;
        if (brc == 0) begin
            q = 1023; r = 0; dz = 1'b1; lat = 0;
        end else begin
            q = arc / brc; r = ((arc % brc) << dac) & 1023; dz = 1'b0; lat = 10 - dac;
        end
    endfunction

    // Called at posedge+1 with the selected DUT idle; returns the result and edges from accept to o_valid.
    task automatic run_op(input int a, input int b, input int ready_delay,
                          output int q, output int r, output bit dz, output int lat, output bit to);
        drv_a = 10'(a); drv_b = 10'(b); drv_valid = 1'b1;
        @(posedge clk); #1;
        drv_valid = 1'b0;
        lat = 0; to = 1'b0;
        while (!mon_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!mon_valid) to = 1'b1;
        q = int'(mon_q); r = int'(mon_r); dz = mon_dz;
        repeat (ready_delay) begin @(posedge clk); #1; end
        drv_ready = 1'b1;
        @(posedge clk); #1;
        drv_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            cur = s; #0;
            tests++; if (mon_ready !== 1'b1) begin fails++; $display("FAIL reset_ready dut%0d got %b exp 1", s, mon_ready); end
            tests++; if (mon_valid !== 1'b0) begin fails++; $display("FAIL reset_valid dut%0d got %b exp 0", s, mon_valid); end
            tests++; if (mon_q !== 10'd0) begin fails++; $display("FAIL reset_q dut%0d got %0d exp 0", s, mon_q); end
            tests++; if (mon_r !== 10'd0) begin fails++; $display("FAIL reset_r dut%0d got %0d exp 0", s, mon_r); end
            tests++; if (mon_dz !== 1'b0) begin fails++; $display("FAIL reset_dz dut%0d got %b exp 0", s, mon_dz); end
        end
        cur = 0;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic check_op(input string tag, input int s, input int a, input int b, input int dly);
        int q, r, lat, eq, er, elat;
        bit dz, edz, to;
        cur = s; #0;
        model(a, b, s + 1, eq, er, edz, elat);
        run_op(a, b, dly, q, r, dz, lat, to);
        tests++;
        if (to) begin
            fails++; $display("FAIL %s_timeout dut%0d a=%0d b=%0d no o_valid", tag, s, a, b);
        end else if (q !== eq || r !== er || dz !== edz || lat !== elat) begin
            fails++;
            $display("FAIL %s dut%0d a=%0d b=%0d got q=%0d r=%0d dz=%0d lat=%0d exp q=%0d r=%0d dz=%0d lat=%0d",
                     tag, s, a, b, q, r, dz, lat, eq, er, edz, elat);
        end
        tests++;
        if (mon_ready !== 1'b1 || mon_valid !== 1'b0) begin
            fails++; $display("FAIL %s_release dut%0d got ready=%b valid=%b exp 1 0", tag, s, mon_ready, mon_valid);
        end
    endtask

    task automatic test_directed();
        check_op("plan_100_7", 0, 100, 7, 0);
        check_op("plan_9_2", 0, 9, 2, 1);
        check_op("plan_sat", 0, 1023, 1, 0);
        check_op("plan_dz", 0, 50, 0, 0);
        check_op("plan_dz_dac2", 1, 50, 1, 0);
        check_op("dac2_sat", 1, 1022, 3, 2);
    endtask

    task automatic test_random();
        int a, b;
        for (int i = 0; i < 60; i++) begin
            a = $urandom_range(0, 1023);
            b = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 1023);
            check_op("random", i % 2, a, b, $urandom_range(0, 3));
        end
    endtask

    task automatic test_backpressure();
        int eq, er, elat, q0;
        bit edz;
        bit bad_valid, bad_ready, bad_q;
        cur = 0; #0;
        model(200, 9, 1, eq, er, edz, elat);
        drv_a = 10'd200; drv_b = 10'd9; drv_valid = 1'b1;
        @(posedge clk); #1;
        drv_valid = 1'b0;
        for (int i = 0; i < 40 && !mon_valid; i++) begin @(posedge clk); #1; end
        q0 = int'(mon_q);
        tests++; if (q0 !== eq) begin fails++; $display("FAIL bp_result got %0d exp %0d", q0, eq); end
        drv_a = 10'd77; drv_b = 10'd3; drv_valid = 1'b1;
        bad_valid = 1'b0; bad_ready = 1'b0; bad_q = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (mon_valid !== 1'b1) bad_valid = 1'b1;
            if (mon_ready !== 1'b0) bad_ready = 1'b1;
            if (int'(mon_q) !== eq) bad_q = 1'b1;
        end
        tests++; if (bad_valid) begin fails++; $display("FAIL bp_valid_hold got dropped exp 1"); end
        tests++; if (bad_ready) begin fails++; $display("FAIL bp_ready_low got 1 exp 0"); end
        tests++; if (bad_q) begin fails++; $display("FAIL bp_q_stable got %0d exp %0d", mon_q, eq); end
        drv_valid = 1'b0; drv_ready = 1'b1;
        @(posedge clk); #1;
        drv_ready = 1'b0;
        tests++;
        if (mon_ready !== 1'b1 || mon_valid !== 1'b0) begin
            fails++; $display("FAIL bp_release got ready=%b valid=%b exp 1 0", mon_ready, mon_valid);
        end
        check_op("bp_next", 0, 300, 11, 0);
    endtask

    task automatic test_reset_mid_calc();
        bit saw_valid;
        cur = 0; #0;
        drv_a = 10'd100; drv_b = 10'd7; drv_valid = 1'b1;
        @(posedge clk); #1;
        drv_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests++;
        if (mon_ready !== 1'b1 || mon_valid !== 1'b0 || mon_q !== 10'd0 || mon_r !== 10'd0 || mon_dz !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_outputs got ready=%b valid=%b q=%0d r=%0d dz=%b exp 1 0 0 0 0",
                     mon_ready, mon_valid, mon_q, mon_r, mon_dz);
        end
        saw_valid = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (mon_valid !== 1'b0) saw_valid = 1'b1;
        end
        tests++; if (saw_valid) begin fails++; $display("FAIL mid_reset_no_valid got pulse exp none"); end
        check_op("after_reset", 0, 100, 7, 0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_calc();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
